// File: rtl/enq_round_arbiter_pkg.sv
// Shared types and helpers for the enqueue round arbiter.
// Round state is sized for the largest supported requester count.
package enq_round_arbiter_pkg;

  localparam int ENQ_ARB_MAX_REQ = 16;
  localparam int ENQ_ARB_PTRW_MAX = 4;
  localparam int ENQ_ARB_CNTW_MAX = 5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [ENQ_ARB_PTRW_MAX-1:0] ptr;
    logic [ENQ_ARB_MAX_REQ-1:0]  served;
    logic [ENQ_ARB_CNTW_MAX-1:0] cnt;
  } round_st_t;

endpackage

// File: rtl/enq_round_arbiter_rr_pick_first.sv
// Round-robin first-set picker: rotate by ptr, priority-encode, rotate back.
// Purely combinational; reusable by any shared-channel arbiter.
module rr_pick_first #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             k_first;
  int             pos;

  always_comb begin
    dbl = {elig, elig} >> ptr;
    rot = dbl[N-1:0];
    k_first = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) k_first = k;
    end
    pos = int'(ptr) + k_first;
    if (pos >= N) pos = pos - N;
    any = |rot;
    grant = '0;
    idx = '0;
    if (any) begin
      grant[pos] = 1'b1;
      idx = W'(pos);
    end
  end

endmodule

// File: rtl/enq_round_arbiter.sv
// Shares one bypass-FIFO enqueue port among NREQ requesters per round.
// Each requester enqueues at most once; the grant pointer survives rounds.
module enq_round_arbiter
  import enq_round_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int PTRW  = clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ-1:0]       REQ_ENQ,
  input  logic [NREQ*WIDTH-1:0] REQ_VALUE,
  output logic [NREQ-1:0]       GRANT,
  input  logic                  CH_NOT_FULL,
  output logic                  CH_ENQ,
  output logic [WIDTH-1:0]      CH_ENQ_VALUE,
  input  logic                  ROUND_RESET,
  output logic                  ROUND_DONE,
  output logic [PTRW:0]         GRANT_COUNT
);

  round_st_t       st;
  round_st_t       st_nxt;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] pick_grant;
  logic [PTRW-1:0] g;
  logic            pick_any;
  logic            gnt;
  logic            unused_st;

  // Upper state bits stay zero when NREQ is below the maximum.
  assign unused_st = ^st;

  assign elig = REQ_VALID & REQ_ENQ
              & ~st.served[NREQ-1:0]
              & {NREQ{CH_NOT_FULL}};

  rr_pick_first #(
    .N (NREQ),
    .W (PTRW)
  ) u_pick (
    .elig  (elig),
    .ptr   (st.ptr[PTRW-1:0]),
    .grant (pick_grant),
    .idx   (g),
    .any   (pick_any)
  );

  assign gnt   = pick_any & ~RST;
  assign GRANT = gnt ? pick_grant : '0;
  assign CH_ENQ = gnt;

  assign CH_ENQ_VALUE = gnt
    ? REQ_VALUE[int'(g)*WIDTH +: WIDTH]
    : '0;

  assign ROUND_DONE = ~RST
    & (&(st.served[NREQ-1:0] | (REQ_VALID & ~REQ_ENQ)));

  assign GRANT_COUNT = RST ? '0 : st.cnt[PTRW:0];

  // Round reset clears served/cnt but a same-cycle grant still moves ptr.
  always_comb begin
    st_nxt = st;
    if (gnt) begin
      st_nxt.served[g] = 1'b1;
      st_nxt.cnt = st.cnt + ENQ_ARB_CNTW_MAX'(1);
      if (int'(g) == NREQ - 1)
        st_nxt.ptr = '0;
      else
        st_nxt.ptr = ENQ_ARB_PTRW_MAX'(g)
                   + ENQ_ARB_PTRW_MAX'(1);
    end
    if (ROUND_RESET) begin
      st_nxt.served = '0;
      st_nxt.cnt = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) st <= '0;
    else     st <= st_nxt;
  end

endmodule

// File: tb/tb_enq_round_arbiter.sv
// Directed bench for enq_round_arbiter (NREQ=4, WIDTH=8).
// Expected values are hand-computed constants.
module tb_enq_round_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ_VALID;
  logic [3:0]  REQ_ENQ;
  logic [31:0] REQ_VALUE;
  logic [3:0]  GRANT;
  logic        CH_NOT_FULL;
  logic        CH_ENQ;
  logic [7:0]  CH_ENQ_VALUE;
  logic        ROUND_RESET;
  logic        ROUND_DONE;
  logic [2:0]  GRANT_COUNT;

  int n_cmp = 0;
  int n_err = 0;

  enq_round_arbiter #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_ENQ      (REQ_ENQ),
    .REQ_VALUE    (REQ_VALUE),
    .GRANT        (GRANT),
    .CH_NOT_FULL  (CH_NOT_FULL),
    .CH_ENQ       (CH_ENQ),
    .CH_ENQ_VALUE (CH_ENQ_VALUE),
    .ROUND_RESET  (ROUND_RESET),
    .ROUND_DONE   (ROUND_DONE),
    .GRANT_COUNT  (GRANT_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic round_reset();
    ROUND_RESET = 1'b1;
    tick();
    ROUND_RESET = 1'b0;
    #1;
  endtask

  logic [7:0] exp_val [4];

  initial begin
    exp_val[0] = 8'h11;
    exp_val[1] = 8'h22;
    exp_val[2] = 8'h33;
    exp_val[3] = 8'h44;
    RST = 1'b1;
    REQ_VALID = 4'b1111;
    REQ_ENQ = 4'b1111;
    REQ_VALUE = 32'h44332211;
    CH_NOT_FULL = 1'b1;
    ROUND_RESET = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(GRANT), 32'h0);
    chk("rst_enq", 32'(CH_ENQ), 32'h0);
    chk("rst_val", 32'(CH_ENQ_VALUE), 32'h0);
    chk("rst_done", 32'(ROUND_DONE), 32'h0);
    chk("rst_cnt", 32'(GRANT_COUNT), 32'h0);

    // Release mid-cycle; round-robin through all four.
    RST = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_grant", 32'(GRANT), 32'(4'b0001 << k));
      chk("rr_val", 32'(CH_ENQ_VALUE), 32'(exp_val[k]));
      chk("rr_cnt", 32'(GRANT_COUNT), 32'(k));
      chk("rr_done", 32'(ROUND_DONE), 32'h0);
      tick();
    end
    chk("rr_end_grant", 32'(GRANT), 32'h0);
    chk("rr_end_done", 32'(ROUND_DONE), 32'h1);
    chk("rr_end_cnt", 32'(GRANT_COUNT), 32'h4);
    round_reset();
    chk("rr_clr_cnt", 32'(GRANT_COUNT), 32'h0);

    // Backpressure: only requester 2, channel full for 3 cycles.
    REQ_VALID = 4'b0100;
    REQ_ENQ = 4'b0100;
    CH_NOT_FULL = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_grant", 32'(GRANT), 32'h0);
      chk("bp_enq", 32'(CH_ENQ), 32'h0);
      tick();
    end
    chk("bp_cnt", 32'(GRANT_COUNT), 32'h0);
    CH_NOT_FULL = 1'b1;
    #1;
    chk("bp_go_grant", 32'(GRANT), 32'h4);
    chk("bp_go_val", 32'(CH_ENQ_VALUE), 32'h33);
    tick();
    chk("bp_cnt1", 32'(GRANT_COUNT), 32'h1);
    round_reset();

    // Mixed done; ptr is 3, scan 3,0,1 picks 1.
    REQ_VALID = 4'b1011;
    REQ_ENQ = 4'b0010;
    #1;
    chk("mx_grant", 32'(GRANT), 32'h2);
    chk("mx_done0", 32'(ROUND_DONE), 32'h0);
    tick();
    chk("mx_grant2", 32'(GRANT), 32'h0);
    chk("mx_done1", 32'(ROUND_DONE), 32'h0);
    REQ_VALID = 4'b1111;
    #1;
    chk("mx_done2", 32'(ROUND_DONE), 32'h1);
    chk("mx_cnt", 32'(GRANT_COUNT), 32'h1);
    round_reset();
    chk("mx_done_clr", 32'(ROUND_DONE), 32'h0);
    chk("mx_cnt_clr", 32'(GRANT_COUNT), 32'h0);

    // Collision: ptr is 2, only 3 wants; round reset same cycle.
    REQ_ENQ = 4'b1000;
    #1;
    chk("col_grant", 32'(GRANT), 32'h8);
    chk("col_val", 32'(CH_ENQ_VALUE), 32'h44);
    round_reset();
    chk("col_cnt", 32'(GRANT_COUNT), 32'h0);
    chk("col_again", 32'(GRANT), 32'h8);
    REQ_ENQ = 4'b1111;
    #1;
    chk("col_ptr0", 32'(GRANT), 32'h1);
    tick();
    tick();
    chk("col_cnt2", 32'(GRANT_COUNT), 32'h2);
    chk("col_next", 32'(GRANT), 32'h4);

    // Async reset between edges after two grants.
    #2;
    RST = 1'b1;
    #1;
    chk("ar_grant", 32'(GRANT), 32'h0);
    chk("ar_enq", 32'(CH_ENQ), 32'h0);
    chk("ar_val", 32'(CH_ENQ_VALUE), 32'h0);
    chk("ar_cnt", 32'(GRANT_COUNT), 32'h0);
    chk("ar_done", 32'(ROUND_DONE), 32'h0);
    tick();
    RST = 1'b0;
    #1;
    chk("ar_rel_cnt", 32'(GRANT_COUNT), 32'h0);
    chk("ar_rel_grant", 32'(GRANT), 32'h1);
    chk("ar_rel_done", 32'(ROUND_DONE), 32'h0);

    // Everyone declines: done with zero grants.
    REQ_ENQ = 4'b0000;
    #1;
    chk("nz_grant", 32'(GRANT), 32'h0);
    chk("nz_done", 32'(ROUND_DONE), 32'h1);
    chk("nz_cnt", 32'(GRANT_COUNT), 32'h0);
    REQ_VALID = 4'b1110;
    #1;
    chk("nz_block", 32'(ROUND_DONE), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/enq_round_arbiter.md
Name: enq_round_arbiter

Overview:
- Shares one single-entry bypass-FIFO enqueue port among NREQ requesters within a model cycle ("round").
- Each requester may enqueue at most once per round. Grants are round-robin, and the grant pointer persists across rounds.
- Produces ROUND_DONE once every requester is resolved for the round, i.e. it has enqueued or has declared a valid no-enqueue.
- Sits between the producer modules and the channel's ENQ/ENQ_VALUE/NOT_FULL pins; the round controller's RESET pulse closes the round.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, payload width in bits (>=1).
- PTRW, clog2(NREQ), pointer width; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- REQ_VALID  in  NREQ  requester i has decided for this round.
- REQ_ENQ  in  NREQ  requester i wants to enqueue; meaningful only when REQ_VALID[i]=1.
- REQ_VALUE  in  NREQ*WIDTH  payload; slice i is bits [i*WIDTH +: WIDTH].
- GRANT  out  NREQ  one-hot grant; the enqueue for i happens this cycle.
- CH_NOT_FULL  in  1  channel NOT_FULL.
- CH_ENQ  out  1  channel ENQ.
- CH_ENQ_VALUE  out  WIDTH  channel ENQ_VALUE.
- ROUND_RESET  in  1  round-end pulse; clears per-round state.
- ROUND_DONE  out  1  all requesters resolved this round.
- GRANT_COUNT  out  PTRW+1  grants issued in the current round.

Behaviour:
- State: ptr[PTRW-1:0], served[NREQ-1:0], cnt[PTRW:0]. All are zero on RST assertion, asynchronously.
- While RST=1, every output is forced to 0: GRANT, CH_ENQ, CH_ENQ_VALUE, ROUND_DONE, GRANT_COUNT.
- Eligibility: elig[i] = REQ_VALID[i] & REQ_ENQ[i] & ~served[i].
- Grant (combinational, zero latency):
  - If CH_NOT_FULL=1 and elig≠0, GRANT is one-hot at the first eligible index scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - Otherwise GRANT=0.
- CH_ENQ = |GRANT. CH_ENQ_VALUE = REQ_VALUE slice of the granted index, or 0 when there is no grant.
- At most one grant per cycle.
- Clock edge with a grant at index g and ROUND_RESET=0:
  - served[g] <= 1.
  - cnt <= cnt+1.
  - ptr <= (g+1) mod NREQ. This wraps correctly for non-power-of-2 NREQ.
- Clock edge with ROUND_RESET=1:
  - served <= 0 and cnt <= 0. This wins over a same-cycle grant; that grant still completes on the channel and counts toward the old round.
  - ptr still advances on a same-cycle grant.
- ROUND_DONE = &(served | (REQ_VALID & ~REQ_ENQ)), combinational.
  - A requester whose REQ_VALID is 0 and that is not served blocks done.
  - Done may be 1 with zero grants (all requesters chose no-enqueue).
- Requester protocol:
  - Once served[i]=1, REQ_ENQ[i] is ignored until ROUND_RESET.
  - A requester must hold REQ_VALID, REQ_ENQ and REQ_VALUE stable until granted or until the round resets.
- Full channel: CH_NOT_FULL=0 produces no grants; ptr and served hold.
- Fairness: with the channel draining every cycle, any eligible requester is granted within NREQ cycles.
- GRANT_COUNT = cnt and saturates at NREQ by construction, since each index is served at most once.
- RST mid-round discards served, cnt and ptr; the first grant after reset release starts the scan at index 0.

Decomposition:
- Shared package holds:
  - clog2 function.
  - ENQ_ARB_MAX_REQ = 16 constant.
  - Round-state record type (ptr, served, cnt).
- One natural sub-module, rr_pick_first: a combinational rotate / priority-encode / rotate-back that takes elig and ptr and returns one-hot GRANT and the index g. It is reusable by other shared-channel arbiters.

Test Plan:
- Reset: RST=1 with all requesters valid+enq and CH_NOT_FULL=1 -> GRANT=0, CH_ENQ=0, ROUND_DONE=0, GRANT_COUNT=0; first cycle after release grants index 0.
- Round-robin: NREQ=4, all valid+enq, CH_NOT_FULL=1 for 4 cycles -> GRANT = 0001, 0010, 0100, 1000; CH_ENQ_VALUE tracks the matching slices (e.g. 0x11, 0x22, 0x33, 0x44); then ROUND_DONE=1 and GRANT_COUNT=4.
- Backpressure: CH_NOT_FULL=0 for 3 cycles with requester 2 eligible -> no grant and ptr unchanged; CH_NOT_FULL=1 -> GRANT=0100 in that same cycle.
- Mixed done: requesters 0 and 3 valid with enq=0, requester 1 valid+enq, requester 2 REQ_VALID=0 -> requester 1 granted, ROUND_DONE=0; assert REQ_VALID[2] with enq=0 -> ROUND_DONE=1 combinationally, GRANT_COUNT=1.
- Reset-vs-grant collision: ROUND_RESET=1 in the same cycle as the grant to index 3 -> next cycle served=0, cnt=0, ptr=0 (wrapped); index 3 is eligible again.
- Async reset mid-round: assert RST between clock edges after 2 grants -> outputs drop to 0 immediately; after release served=0, ptr=0, GRANT_COUNT=0.
